// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard control unit.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and memory-wait freeze control.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  state_t state_q, state_n, ret_q, ret_n, cur;
  logic [3:0] cnt_q, cnt_n;
  logic load_use, mem_busy, frozen, flush_inc;
  assign load_use = ID_EX_MemRead && ID_EX_rd != '0 &&
                    ((IF_ID_use_rs1 && ID_EX_rd == IF_ID_rs1) || (IF_ID_use_rs2 && ID_EX_rd == IF_ID_rs2));
  assign mem_busy = mem_req && !mem_ready;
  assign frozen   = state_q == MEM_WAIT && !mem_ready;
  // On the ready cycle of a memory wait, act as the state we were interrupted in.
  assign cur      = state_q == MEM_WAIT ? ret_q : state_q;
  assign state    = state_q;
  always_comb begin
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_flush = 1'b0;
    hold = 1'b0;
    flush_inc = 1'b0;
    state_n = state_q;
    ret_n = ret_q;
    cnt_n = cnt_q;
    if (!rst_n) begin
      state_n = RUN;
    end else if (frozen) begin
      hold = 1'b1;
      pc_write = 1'b0;
      if_id_write = 1'b0;
    end else if (cur != RUN && cur != LOAD_STALL) begin
      state_n = RUN;
    end else if (mem_busy) begin
      hold = 1'b1;
      pc_write = 1'b0;
      if_id_write = 1'b0;
      ret_n = cur;
      state_n = MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc = 1'b1;
      state_n = RUN;
      cnt_n = '0;
    end else if (cur == LOAD_STALL || load_use) begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (cur == RUN) begin
        state_n = LOAD_STALL_CYCLES == 1 ? RUN : LOAD_STALL;
        cnt_n = LOAD_STALL_CYCLES == 1 ? cnt_q : 4'(LOAD_STALL_CYCLES - 1);
      end else begin
        state_n = cnt_q == 4'd1 ? RUN : LOAD_STALL;
        cnt_n = cnt_q == 4'd1 ? cnt_q : cnt_q - 4'd1;
      end
    end else begin
      state_n = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      ret_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_n;
      ret_q <= ret_n;
      cnt_q <= cnt_n;
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc(!pc_write), .count(stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst_n(rst_n), .inc(flush_inc), .count(flush_events));
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench driving a 1-bubble and a 3-bubble (3-bit counter) unit in parallel.
module tb_hazard_control_unit;
  logic clk = 0, rst_n;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, mr, br, req, rdy;
  logic pw1, iw1, iff1, idf1, emf1, h1, pw3, iw3, iff3, idf3, emf3, h3;
  logic [1:0] st1, st3;
  logic [31:0] sc1, fe1;
  logic [2:0] sc3, fe3;
  int total = 0, bad = 0;
  int es1 = 0, ef1 = 0, es3 = 0, ef3 = 0;
  localparam logic [5:0] D = 6'b110000, S = 6'b000100, H = 6'b000001, B = 6'b111110;
  typedef struct {string tag; logic [7:0] e1; logic [7:0] e3;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EX_rd(rd), .ID_EX_MemRead(mr), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
    .pc_write(pw1), .if_id_write(iw1), .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(emf1),
    .hold(h1), .state(st1), .stall_cycles(sc1), .flush_events(fe1));
  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EX_rd(rd), .ID_EX_MemRead(mr), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
    .pc_write(pw3), .if_id_write(iw3), .if_id_flush(iff3), .id_ex_flush(idf3), .ex_mem_flush(emf3),
    .hold(h3), .state(st3), .stall_cycles(sc3), .flush_events(fe3));
  logic [7:0] v1, v3;
  assign v1 = {pw1, iw1, iff1, idf1, emf1, h1, st1};
  assign v3 = {pw3, iw3, iff3, idf3, emf3, h3, st3};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                       input logic [4:0] d, input logic m, input logic t, input logic q, input logic r);
    rs1 = a; use1 = ua; rs2 = b; use2 = ub; rd = d; mr = m; br = t; req = q; rdy = r;
  endtask
  task automatic cyc(input string tag, input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                     input logic [4:0] d, input logic m, input logic t, input logic q, input logic r,
                     input logic [7:0] x1, input logic [7:0] x3);
    exp_t e;
    drive(a, ua, b, ub, d, m, t, q, r);
    sb.push_back('{tag, x1, x3});
    if (!x1[7]) es1++;
    if (x1[5]) ef1++;
    if (!x3[7] && es3 < 7) es3++;
    if (x3[5] && ef3 < 7) ef3++;
    #3;
    e = sb.pop_front();
    check({e.tag, "/u1"}, 32'(v1), 32'(e.e1));
    check({e.tag, "/u3"}, 32'(v3), 32'(e.e3));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string tag, input logic [7:0] x1, input logic [7:0] x3);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, x1, x3);
  endtask
  task automatic counters(input string tag);
    check({tag, "/sc1"}, sc1, 32'(es1));
    check({tag, "/fe1"}, fe1, 32'(ef1));
    check({tag, "/sc3"}, 32'(sc3), 32'(es3));
    check({tag, "/fe3"}, 32'(fe3), 32'(ef3));
  endtask
  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst/u1", 32'(v1), 32'({D, 2'd0}));
    check("rst/u3", 32'(v3), 32'({D, 2'd0}));
    counters("rst");
    #9 rst_n = 1;
    @(posedge clk);
    #1;
    cyc("lu", 5, 1, 7, 1, 5, 1, 0, 0, 0, {S, 2'd0}, {S, 2'd0});
    idle("lu+1", {D, 2'd0}, {S, 2'd1});
    idle("lu+2", {D, 2'd0}, {S, 2'd1});
    idle("lu+3", {D, 2'd0}, {D, 2'd0});
    counters("lu");
    cyc("x0", 0, 1, 0, 1, 0, 1, 0, 0, 0, {D, 2'd0}, {D, 2'd0});
    cyc("rs2_unused", 3, 1, 6, 0, 6, 1, 0, 0, 0, {D, 2'd0}, {D, 2'd0});
    cyc("no_load", 6, 1, 6, 1, 6, 0, 0, 0, 0, {D, 2'd0}, {D, 2'd0});
    cyc("mw0", 0, 0, 0, 0, 0, 0, 0, 1, 0, {H, 2'd0}, {H, 2'd0});
    for (int i = 1; i < 4; i++) cyc("mw", 0, 0, 0, 0, 0, 0, 0, 1, 0, {H, 2'd2}, {H, 2'd2});
    cyc("mw_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1, {D, 2'd2}, {D, 2'd2});
    idle("mw_end", {D, 2'd0}, {D, 2'd0});
    counters("mw");
    cyc("br_a", 5, 1, 0, 0, 5, 1, 0, 0, 0, {S, 2'd0}, {S, 2'd0});
    cyc("br_b", 0, 0, 0, 0, 0, 0, 1, 0, 0, {B, 2'd0}, {B, 2'd1});
    idle("br_c", {D, 2'd0}, {D, 2'd0});
    counters("br");
    cyc("lsm_a", 5, 1, 0, 0, 5, 1, 0, 0, 0, {S, 2'd0}, {S, 2'd0});
    cyc("lsm_b", 0, 0, 0, 0, 0, 0, 0, 1, 0, {H, 2'd0}, {H, 2'd1});
    cyc("lsm_c", 0, 0, 0, 0, 0, 0, 0, 1, 1, {D, 2'd2}, {S, 2'd2});
    idle("lsm_d", {D, 2'd0}, {S, 2'd1});
    idle("lsm_e", {D, 2'd0}, {D, 2'd0});
    counters("lsm");
    cyc("pr_a", 0, 0, 0, 0, 0, 0, 1, 1, 0, {H, 2'd0}, {H, 2'd0});
    cyc("pr_b", 0, 0, 0, 0, 0, 0, 1, 1, 1, {B, 2'd2}, {B, 2'd2});
    cyc("pr_c", 9, 1, 0, 0, 9, 1, 1, 0, 0, {B, 2'd0}, {B, 2'd0});
    idle("pr_d", {D, 2'd0}, {D, 2'd0});
    counters("pr");
    cyc("ar_a", 0, 0, 0, 0, 0, 0, 0, 1, 0, {H, 2'd0}, {H, 2'd0});
    cyc("ar_b", 0, 0, 0, 0, 0, 0, 0, 1, 0, {H, 2'd2}, {H, 2'd2});
    #2 rst_n = 0;
    #1;
    check("arst/u1", 32'(v1), 32'({D, 2'd0}));
    check("arst/u3", 32'(v3), 32'({D, 2'd0}));
    es1 = 0; ef1 = 0; es3 = 0; ef3 = 0;
    counters("arst");
    #2 rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    idle("post_rst", {D, 2'd0}, {D, 2'd0});
    counters("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side companion to the EX-stage forwarding logic. Forwarding resolves RAW hazards that can be bypassed; this block handles the hazards that cannot be bypassed:
  - load-use stalls, including a multi-cycle load-to-use latency;
  - control flushes on a taken branch;
  - full-pipeline freezes while the shared multi-cycle data memory is busy.
- It sits beside the pipeline registers and drives their write-enable, flush and hold controls. It also keeps saturating performance counters.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_rs1  in  5  rs1 of the instruction in decode.
- IF_ID_rs2  in  5  rs2 of the instruction in decode.
- IF_ID_use_rs1  in  1  decode instruction reads rs1.
- IF_ID_use_rs2  in  1  decode instruction reads rs2.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- branch_taken  in  1  branch/jump resolved taken in the MEM stage.
- mem_req  in  1  MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to a bubble.
- ex_mem_flush  out  1  clear EX/MEM to a bubble.
- hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- state  out  2  current FSM state (debug).
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- flush_events  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, stall counter=0, return-state=RUN, both performance counters=0.
  - Outputs during reset: pc_write=1, if_id_write=1, every flush=0, hold=0.
- Outputs are Mealy: they are a combinational function of the current state and the current inputs, so there is zero-cycle latency from hazard to control.
- Defaults: pc_write=1, if_id_write=1, all flushes=0, hold=0.
- load_use = ID_EX_MemRead & (ID_EX_rd!=0) & ((IF_ID_use_rs1 & ID_EX_rd==IF_ID_rs1) | (IF_ID_use_rs2 & ID_EX_rd==IF_ID_rs2)).
- mem_busy = mem_req & !mem_ready.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2. Encoding 3 is unused and returns to RUN.
- Priority in RUN and LOAD_STALL, highest first: mem_busy, then branch_taken, then load-use/stall.
- Memory busy (mem_busy=1):
  - Outputs: hold=1, pc_write=0, if_id_write=0, no flushes.
  - Save the current state as return-state, then enter MEM_WAIT.
  - The stall counter is frozen.
- Taken branch (branch_taken=1):
  - Outputs: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_write=1, if_id_write=1.
  - flush_events increments.
  - Next state is RUN and the stall counter clears; a branch aborts any pending load stall.
- Load stall:
  - Condition: in RUN with load_use=1, or in LOAD_STALL.
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
  - From RUN: if LOAD_STALL_CYCLES=1, stay in RUN. Otherwise load the counter with LOAD_STALL_CYCLES-1 and enter LOAD_STALL.
  - In LOAD_STALL: if counter==1, go to RUN; else decrement.
  - Total bubbles per hazard = LOAD_STALL_CYCLES.
- MEM_WAIT:
  - While mem_ready=0: hold=1, pc_write=0, if_id_write=0.
  - branch_taken and load_use are ignored, because the stages are frozen and the inputs will be re-presented.
  - When mem_ready=1: hold=0 in that same cycle, and that cycle is evaluated by the return-state rules (branch, then load stall). The next state follows those rules.
  - mem_req asserted again in the following cycle is treated as a new access.
- stall_cycles increments every cycle with pc_write=0.
- Both performance counters saturate at all-ones and never wrap.
- x0 never causes a stall.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encoding constants RUN, LOAD_STALL, MEM_WAIT;
  - the NOP/bubble constant used by the flush targets;
  - the register-index width (5).
- One natural sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count). It is instantiated twice, for stall_cycles and flush_events.

Test Plan:
- Load x5, then add x6,x5,x7 (use_rs1=1, LOAD_STALL_CYCLES=1) -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; then state RUN; stall_cycles=1.
- Same sequence with LOAD_STALL_CYCLES=3 -> 3 consecutive stall cycles with state 0→1→1→0; stall_cycles=3.
- Load to x0 with rs1=0, or a match only on rs2 with use_rs2=0 -> no stall; all defaults held.
- mem_req=1 with mem_ready low for 4 cycles, then high -> hold=1 and pc_write=0 for 4 cycles, hold=0 in the ready cycle; state 0→2 (×4)→0.
- branch_taken in the second cycle of a 3-cycle load stall -> three flushes asserted that cycle, pc_write=1, state→RUN, flush_events=1.
- rst_n pulsed low mid MEM_WAIT -> outputs return to defaults immediately, without a clock; both counters read 0.
